spi_slave_frame_rx: RTL and testbench

- Synthesizable SPI Mode 0 (CPOL=0, CPHA=0) slave for the FPGA side.
- Consumes the command/address/payload frames issued by the ESP32 SPI master (and by its simulation mock-up).
- Oversamples sclk/cs/mosi on sysclk, decodes an 8-bit command, then either emits a register-write strobe or fetches a register and shifts its value back on miso.
- Sits between the external SPI pins and the register file / brightness-control logic.

---
 rtl/spi_slave_frame_rx_if.sv | 45 ++++
 rtl/spi_slave_frame_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_slave_frame_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_frame_rx_if.sv
// ---------------------------------------------------------------------------
// spi_slave_frame_rx_if
//   Bundles the SPI pins and the register-file side of spi_slave_frame_rx.
//
//   SPI side     : sclk, cs (active low), mosi in; miso out.
//   Register side: wr_valid/wr_addr/wr_data write strobe,
//                  rd_req/rd_addr read request, rd_data read return,
//                  busy (cs asserted, synchronized), frame_err pulse.
//
//   Handshake semantics: there is no back-pressure. wr_valid, rd_req and
//   frame_err are single-sysclk pulses; the consumer must accept them in the
//   cycle they are high. wr_addr/wr_data are valid with wr_valid, rd_addr is
//   valid from rd_req until frame end, and rd_data must be presented no later
//   than one sysclk after rd_req and held until the frame ends.
//
//   Modports: slave = the receiver block, master = whoever drives the pins
//   and serves the register reads.
// ---------------------------------------------------------------------------
interface spi_slave_frame_rx_if #(
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8
) ();
    logic                    sclk;
    logic                    cs;
    logic                    mosi;
    logic                    miso;
    logic                    wr_valid;
    logic [ADDR_BITS-1:0]    wr_addr;
    logic [PAYLOAD_BITS-1:0] wr_data;
    logic                    rd_req;
    logic [ADDR_BITS-1:0]    rd_addr;
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    busy;
    logic                    frame_err;

    modport slave (
        input  sclk, cs, mosi, rd_data,
        output miso, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, frame_err
    );

    modport master (
        output sclk, cs, mosi, rd_data,
        input  miso, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_frame_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_frame_rx
//   SPI mode 0 slave, oversampled on sysclk. Decodes a command byte, an
//   address and a payload. Write frames end in a wr_valid strobe; read frames
//   raise rd_req, load the returned register value and shift it out on miso.
//
//   Ports:
//     sysclk    : system clock (sclk must be <= sysclk/8)
//     rst_n     : asynchronous active-low reset
//     bus       : spi_slave_frame_rx_if.slave (SPI pins + register side)
//     dbg_state : current FSM state encoding
// ---------------------------------------------------------------------------
module spi_slave_frame_rx #(
    parameter int                    CMD_BITS     = 8,
    parameter int                    ADDR_BITS    = 8,
    parameter int                    PAYLOAD_BITS = 8,
    parameter logic [CMD_BITS-1:0]   CMD_WRITE    = 8'h02,
    parameter logic [CMD_BITS-1:0]   CMD_READ     = 8'h03
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    spi_slave_frame_rx_if.slave   bus,
    output logic [2:0]            dbg_state
);

    localparam int SR_A  = (CMD_BITS > ADDR_BITS) ? CMD_BITS : ADDR_BITS;
    localparam int SR_W  = (SR_A > PAYLOAD_BITS) ? SR_A : PAYLOAD_BITS;
    localparam int CNT_W = $clog2(SR_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMMAND = 3'd1,
        ST_ADDRESS = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4,
        ST_DONE    = 3'd5,
        ST_IGNORE  = 3'd6
    } state_t;

    state_t state, state_next;

    // Synchronizers. cs resets to its inactive (high) level so that busy is
    // low out of reset and no spurious frame start is seen.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;

    logic sclk_rise, sclk_fall, cs_hi;

    logic [CNT_W-1:0]        bit_cnt;
    logic [SR_W-1:0]         sr;
    logic [SR_W-1:0]         sr_next;
    logic                    is_wr, is_rd;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [PAYLOAD_BITS-1:0] tx_q;
    logic                    rd_req_d;

    logic                    wr_valid_q, rd_req_q, frame_err_q;
    logic [ADDR_BITS-1:0]    wr_addr_q, rd_addr_q;
    logic [PAYLOAD_BITS-1:0] wr_data_q;

    // Control strobes from the next-state logic.
    logic clr_cnt, err_set, wr_set, rdreq_set;
    logic set_wr_flag, set_rd_flag, addr_load, active;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= bus.cs;
            cs_s2   <= cs_s1;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_hi     = cs_s2;
    assign sr_next   = {sr[SR_W-2:0], mosi_s2};
    assign active    = (state == ST_COMMAND) || (state == ST_ADDRESS) ||
                       (state == ST_WRITE)   || (state == ST_READ);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic. cs deassertion is checked first in every shifting
    // state, so a cs rise seen together with the last bit aborts the frame.
    always_comb begin
        state_next  = state;
        clr_cnt     = 1'b0;
        err_set     = 1'b0;
        wr_set      = 1'b0;
        rdreq_set   = 1'b0;
        set_wr_flag = 1'b0;
        set_rd_flag = 1'b0;
        addr_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                clr_cnt = 1'b1;
                if (!cs_hi) state_next = ST_COMMAND;
            end
            ST_COMMAND: begin
                if (cs_hi) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                    clr_cnt = 1'b1;
                    if (sr_next[CMD_BITS-1:0] == CMD_WRITE) begin
                        state_next  = ST_ADDRESS;
                        set_wr_flag = 1'b1;
                    end else if (sr_next[CMD_BITS-1:0] == CMD_READ) begin
                        state_next  = ST_ADDRESS;
                        set_rd_flag = 1'b1;
                    end else begin
                        state_next = ST_IGNORE;
                        err_set    = 1'b1;
                    end
                end
            end
            ST_ADDRESS: begin
                if (cs_hi) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                    clr_cnt   = 1'b1;
                    addr_load = 1'b1;
                    if (is_wr) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                        rdreq_set  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (cs_hi) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_cnt == CNT_W'(PAYLOAD_BITS - 1)) begin
                    clr_cnt    = 1'b1;
                    wr_set     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_READ: begin
                if (cs_hi) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_cnt == CNT_W'(PAYLOAD_BITS - 1)) begin
                    clr_cnt    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE, ST_IGNORE: begin
                if (cs_hi) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            sr          <= '0;
            is_wr       <= 1'b0;
            is_rd       <= 1'b0;
            addr_q      <= '0;
            tx_q        <= '0;
            rd_req_d    <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
        end else begin
            wr_valid_q  <= wr_set;
            rd_req_q    <= rdreq_set;
            frame_err_q <= err_set;
            rd_req_d    <= rd_req_q;

            if (clr_cnt)                  bit_cnt <= '0;
            else if (sclk_rise && active) bit_cnt <= bit_cnt + 1'b1;

            if (sclk_rise && active) sr <= sr_next;

            if (state == ST_IDLE) begin
                is_wr <= 1'b0;
                is_rd <= 1'b0;
            end else begin
                if (set_wr_flag) is_wr <= 1'b1;
                if (set_rd_flag) is_rd <= 1'b1;
            end

            if (addr_load) addr_q <= sr_next[ADDR_BITS-1:0];
            if (rdreq_set) rd_addr_q <= sr_next[ADDR_BITS-1:0];

            if (wr_set) begin
                wr_addr_q <= addr_q;
                wr_data_q <= sr_next[PAYLOAD_BITS-1:0];
            end

            // rd_data is taken one cycle after rd_req. The falling edge that
            // ends the last address bit must not shift (the MSB goes out on
            // it), so shifting starts only once a data bit has been clocked.
            if (rd_req_d)
                tx_q <= bus.rd_data;
            else if (state == ST_READ && sclk_fall && bit_cnt != '0)
                tx_q <= {tx_q[PAYLOAD_BITS-2:0], 1'b0};
        end
    end

    assign bus.miso      = (state == ST_READ) ? tx_q[PAYLOAD_BITS-1] : 1'b0;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.busy      = ~cs_s2;
    assign bus.frame_err = frame_err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_frame_rx
//   Bench for spi_slave_frame_rx: acts as SPI master at sclk = sysclk/10,
//   serves register reads, and checks write strobes against an expected
//   queue filled when each write frame is issued.
// ---------------------------------------------------------------------------
module tb_spi_slave_frame_rx;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IGNORE = 3'd6;

    // ---------------- clock / reset ----------------
    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [2:0] dbg_state;

    always #4 sysclk = ~sysclk;

    spi_slave_frame_rx_if bus_if ();

    spi_slave_frame_rx dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  rd_value = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops expected writes, serves reads, counts pulses.
    always @(negedge sysclk) begin
        if (rst_n) begin
            if (bus_if.wr_valid) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(bus_if.wr_addr), 32'(exp_e[15:8]));
                    check_eq("wr_data", 32'(bus_if.wr_data), 32'(exp_e[7:0]));
                end
            end
            if (bus_if.rd_req) begin
                rd_cnt++;
                bus_if.rd_data = rd_value;
            end
            if (bus_if.frame_err) err_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cs_begin();
        @(negedge sysclk);
        bus_if.cs = 1'b0;
    endtask

    task automatic cs_end();
        #40;
        bus_if.cs = 1'b1;
        #160;
    endtask

    // Mode 0: mosi changes while sclk is low, miso is sampled just before
    // the rising edge.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus_if.mosi = b[i];
            #40;
            rx = {rx[6:0], bus_if.miso};
            bus_if.sclk = 1'b1;
            #40;
            bus_if.sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] rx);
        send_bits(b, 8, rx);
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rx;
        exp_q.push_back({a, d});
        cs_begin();
        send_byte(8'h02, rx);
        send_byte(a, rx);
        send_byte(d, rx);
        cs_end();
    endtask

    task automatic read_frame(input logic [7:0] a, input logic [7:0] v, input string tag);
        logic [7:0] rx;
        int         r0, e0;
        r0 = rd_cnt;
        e0 = err_cnt;
        rd_value = v;
        cs_begin();
        send_byte(8'h03, rx);
        send_byte(a, rx);
        send_byte(8'h00, rx);
        check_eq({tag, "_miso_byte"}, 32'(rx), 32'(v));
        check_eq({tag, "_rd_addr"}, 32'(bus_if.rd_addr), 32'(a));
        check_eq({tag, "_rd_req_cnt"}, 32'(rd_cnt - r0), 32'd1);
        cs_end();
        check_eq({tag, "_miso_idle"}, 32'(bus_if.miso), 32'd0);
        check_eq({tag, "_no_err"}, 32'(err_cnt - e0), 32'd0);
        bus_if.rd_data = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rx;
        int         w0, r0, e0;
        logic [7:0] ra, rd;

        rst_n          = 1'b0;
        bus_if.cs      = 1'b1;
        bus_if.sclk    = 1'b0;
        bus_if.mosi    = 1'b0;
        bus_if.rd_data = 8'h00;
        repeat (5) @(negedge sysclk);
        check_eq("rst_state",     32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_busy",      32'(bus_if.busy), 32'd0);
        check_eq("rst_outputs",   32'({bus_if.miso, bus_if.wr_valid, bus_if.rd_req, bus_if.frame_err}), 32'd0);
        check_eq("rst_regs",      32'({bus_if.wr_addr, bus_if.wr_data, bus_if.rd_addr}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);

        // Plain write.
        w0 = wr_cnt; e0 = err_cnt;
        write_frame(8'h10, 8'hA5);
        check_eq("wr1_cnt", 32'(wr_cnt - w0), 32'd1);
        check_eq("wr1_err", 32'(err_cnt - e0), 32'd0);

        // Read frame, then one with random address and value.
        w0 = wr_cnt;
        read_frame(8'h22, 8'h5C, "rd1");
        ra = 8'($urandom_range(0, 255));
        rd = 8'($urandom_range(0, 255));
        read_frame(ra, rd, "rd2");
        check_eq("rd_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Unknown command.
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        cs_begin();
        send_byte(8'h7F, rx);
        check_eq("unk_err_after_cmd", 32'(err_cnt - e0), 32'd1);
        check_eq("unk_state", 32'(dbg_state), 32'(ST_IGNORE));
        send_byte(8'h55, rx);
        send_byte(8'hAA, rx);
        cs_end();
        check_eq("unk_err_total", 32'(err_cnt - e0), 32'd1);
        check_eq("unk_no_wr", 32'(wr_cnt - w0), 32'd0);
        check_eq("unk_no_rd", 32'(rd_cnt - r0), 32'd0);
        check_eq("unk_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Abort after 4 payload bits, then a valid write.
        w0 = wr_cnt; e0 = err_cnt;
        cs_begin();
        send_byte(8'h02, rx);
        send_byte(8'h44, rx);
        send_bits(8'hF0, 4, rx);
        cs_end();
        check_eq("abort_err", 32'(err_cnt - e0), 32'd1);
        check_eq("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
        check_eq("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
        write_frame(8'h01, 8'h3C);
        check_eq("post_abort_wr", 32'(wr_cnt - w0), 32'd1);

        // Reset in the middle of the address field.
        cs_begin();
        send_byte(8'h02, rx);
        send_bits(8'h12, 4, rx);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("mid_rst_outputs", 32'({bus_if.miso, bus_if.wr_valid, bus_if.rd_req, bus_if.frame_err, bus_if.busy}), 32'd0);
        check_eq("mid_rst_regs", 32'({bus_if.wr_addr, bus_if.wr_data, bus_if.rd_addr}), 32'd0);
        bus_if.cs   = 1'b1;
        bus_if.sclk = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);
        w0 = wr_cnt;
        write_frame(8'hFF, 8'h00);
        check_eq("post_rst_wr", 32'(wr_cnt - w0), 32'd1);

        // Back-to-back writes with a short cs-high gap.
        w0 = wr_cnt; e0 = err_cnt;
        exp_q.push_back({8'h5A, 8'hC3});
        cs_begin();
        send_byte(8'h02, rx);
        check_eq("b2b_busy_in_frame", 32'(bus_if.busy), 32'd1);
        send_byte(8'h5A, rx);
        send_byte(8'hC3, rx);
        #40;
        bus_if.cs = 1'b1;
        #80;
        check_eq("b2b_busy_gap", 32'(bus_if.busy), 32'd0);
        #80;
        ra = 8'($urandom_range(0, 255));
        rd = 8'($urandom_range(0, 255));
        write_frame(ra, rd);
        check_eq("b2b_wr_cnt", 32'(wr_cnt - w0), 32'd2);
        check_eq("b2b_err", 32'(err_cnt - e0), 32'd0);

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
